// File: rtl/ysyx_23060191_ifu.sv
// Instruction fetch unit: one bus read per pc, one-entry instruction buffer toward decode,
// with misalignment, bus-error and response-timeout reporting through inst_err.
module ysyx_23060191_ifu #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter int                 TIMEOUT  = 255,
    parameter logic [INST_W-1:0]  RST_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              pc_wen,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rsp_valid,
    input  logic [INST_W-1:0] rsp_data,
    input  logic              rsp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [1:0]        inst_err
);

    localparam int            TW  = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

    localparam logic [1:0] E_OK  = 2'b00;
    localparam logic [1:0] E_MIS = 2'b01;
    localparam logic [1:0] E_BUS = 2'b10;
    localparam logic [1:0] E_TMO = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic [ADDR_W-1:0] addr_q;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic [1:0]        err_q;
    logic              drop_pend_q;  // timed-out response still owed by the bus
    logic              aligned;

    assign aligned    = (pc[1:0] == 2'b00);
    assign req_valid  = (state_q == S_REQ) && aligned && !flush;
    assign req_addr   = (state_q == S_REQ) ? pc : addr_q;
    assign inst_valid = (state_q == S_HOLD) && !flush;
    assign pc_wen     = (state_q == S_HOLD) && inst_ready && !flush;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_err   = err_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            addr_q      <= '0;
            inst_q      <= RST_INST;
            inst_pc_q   <= '0;
            err_q       <= E_OK;
            drop_pend_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_REQ;
                S_REQ: begin
                    if (flush) begin
                        state_q <= S_REQ;
                    end else if (!aligned) begin
                        inst_q    <= RST_INST;
                        inst_pc_q <= pc;
                        err_q     <= E_MIS;
                        state_q   <= S_HOLD;
                    end else if (req_ready) begin
                        addr_q  <= pc;
                        timer_q <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        if (flush) begin
                            state_q <= S_REQ;
                        end else begin
                            inst_q    <= rsp_err ? RST_INST : rsp_data;
                            inst_pc_q <= addr_q;
                            err_q     <= rsp_err ? E_BUS : E_OK;
                            state_q   <= S_HOLD;
                        end
                    end else if (flush) begin
                        state_q <= S_DROP;
                    end else if (timer_q == TMO) begin
                        // present the timeout first, then drain the late response
                        inst_q      <= RST_INST;
                        inst_pc_q   <= addr_q;
                        err_q       <= E_TMO;
                        drop_pend_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_DROP: begin
                    if (rsp_valid) state_q <= S_REQ;
                end
                S_HOLD: begin
                    if (flush || inst_ready) begin
                        state_q     <= drop_pend_q ? S_DROP : S_REQ;
                        drop_pend_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060191_ifu.sv
// Bench for the IFU: directed scenarios plus a randomized run scored against a
// PC-unit / memory / decoder model kept at the transaction level.
module tb_ysyx_23060191_ifu;

    localparam int          TMO  = 8;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rstn, flush, req_ready, rsp_valid, rsp_err, inst_ready;
    logic [31:0] pc, rsp_data;
    logic        pc_wen, req_valid, inst_valid;
    logic [31:0] req_addr, inst, inst_pc;
    logic [1:0]  inst_err;

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    ysyx_23060191_ifu #(.ADDR_W(32), .INST_W(32), .TIMEOUT(TMO), .RST_INST(NOP)) dut (
        .clk(clk), .rstn(rstn), .pc(pc), .flush(flush), .pc_wen(pc_wen),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_err(inst_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'h5A5A1234 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic do_reset();
        rstn = 1'b0; flush = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        rsp_err = 1'b0; rsp_data = '0; inst_ready = 1'b0;
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        pc = 32'h80000000;
        rstn = 1'b0; flush = 1'b0; req_ready = 1'b1; rsp_valid = 1'b1;
        rsp_err = 1'b0; rsp_data = 32'hdeadbeef; inst_ready = 1'b1;
        tick(); tick();
        vecs++; if ({req_valid, pc_wen, inst_valid} !== 3'b000) begin miss++; $display("FAIL reset_valids got %b exp 000", {req_valid, pc_wen, inst_valid}); end
        vecs++; if (inst !== NOP || inst_pc !== 32'h0 || inst_err !== 2'b00) begin miss++; $display("FAIL reset_buffer got %h/%h/%b exp %h/0/00", inst, inst_pc, inst_err, NOP); end
        vecs++; if (req_addr !== 32'h0) begin miss++; $display("FAIL reset_req_addr got %h exp 0", req_addr); end
        rstn = 1'b1; rsp_valid = 1'b0; inst_ready = 1'b0;
        #1;
        vecs++; if (req_valid !== 1'b0) begin miss++; $display("FAIL idle_req_valid got %b exp 0", req_valid); end
        tick();
        vecs++; if (req_valid !== 1'b1 || req_addr !== pc) begin miss++; $display("FAIL first_req got %b/%h exp 1/%h", req_valid, req_addr, pc); end
    endtask

    task automatic test_basic();
        do_reset();
        pc = 32'h80000000;
        tick();
        req_ready = 1'b1; #1;
        vecs++; if (req_valid !== 1'b1 || req_addr !== 32'h80000000) begin miss++; $display("FAIL basic_req got %b/%h exp 1/80000000", req_valid, req_addr); end
        tick();
        req_ready = 1'b0; #1;
        vecs++; if (inst_valid !== 1'b0 || req_valid !== 1'b0) begin miss++; $display("FAIL basic_wait got %b/%b exp 0/0", inst_valid, req_valid); end
        tick();
        rsp_valid = 1'b1; rsp_data = 32'h00100093; rsp_err = 1'b0; #1;
        vecs++; if (inst_valid !== 1'b0) begin miss++; $display("FAIL basic_rsp_cycle got %b exp 0", inst_valid); end
        tick();
        rsp_valid = 1'b0; #1;
        vecs++; if (inst_valid !== 1'b1 || inst !== 32'h00100093 || inst_pc !== 32'h80000000 || inst_err !== 2'b00)
            begin miss++; $display("FAIL basic_hold got %b/%h/%h/%b exp 1/00100093/80000000/00", inst_valid, inst, inst_pc, inst_err); end
        vecs++; if (pc_wen !== 1'b0) begin miss++; $display("FAIL basic_no_wen got %b exp 0", pc_wen); end
        inst_ready = 1'b1; #1;
        vecs++; if (pc_wen !== 1'b1) begin miss++; $display("FAIL basic_wen got %b exp 1", pc_wen); end
        tick();
        inst_ready = 1'b0; pc = 32'h80000004; #1;
        vecs++; if (pc_wen !== 1'b0 || inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h80000004)
            begin miss++; $display("FAIL basic_next got %b/%b/%b/%h exp 0/0/1/80000004", pc_wen, inst_valid, req_valid, req_addr); end
    endtask

    task automatic test_req_stall();
        for (int i = 0; i < 5; i++) begin
            vecs++; if (req_valid !== 1'b1 || req_addr !== 32'h80000004 || pc_wen !== 1'b0)
                begin miss++; $display("FAIL req_stall_%0d got %b/%h/%b exp 1/80000004/0", i, req_valid, req_addr, pc_wen); end
            tick(); #1;
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h00208113;
        tick();
        rsp_valid = 1'b0; #1;
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 4; i++) begin
            vecs++; if (inst_valid !== 1'b1 || inst !== 32'h00208113 || inst_pc !== 32'h80000004 || pc_wen !== 1'b0)
                begin miss++; $display("FAIL hold_stall_%0d got %b/%h/%h/%b exp 1/00208113/80000004/0", i, inst_valid, inst, inst_pc, pc_wen); end
            tick(); #1;
        end
        inst_ready = 1'b1; #1;
        vecs++; if (pc_wen !== 1'b1) begin miss++; $display("FAIL hold_accept got %b exp 1", pc_wen); end
        tick();
        inst_ready = 1'b0; pc = 32'h80000002;
    endtask

    task automatic test_misaligned();
        #1;
        vecs++; if (req_valid !== 1'b0) begin miss++; $display("FAIL mis_no_req got %b exp 0", req_valid); end
        tick(); #1;
        vecs++; if (inst_valid !== 1'b1 || inst !== NOP || inst_pc !== 32'h80000002 || inst_err !== 2'b01 || req_valid !== 1'b0)
            begin miss++; $display("FAIL mis_hold got %b/%h/%h/%b exp 1/%h/80000002/01", inst_valid, inst, inst_pc, inst_err, NOP); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0; pc = 32'h80000010;
    endtask

    task automatic test_timeout();
        int n;
        req_ready = 1'b1; #1;
        vecs++; if (req_valid !== 1'b1 || req_addr !== 32'h80000010) begin miss++; $display("FAIL tmo_req got %b/%h exp 1/80000010", req_valid, req_addr); end
        tick();
        req_ready = 1'b0; n = 0; #1;
        while (inst_valid !== 1'b1 && n < 40) begin tick(); n++; #1; end
        vecs++; if (n != TMO + 1) begin miss++; $display("FAIL tmo_cycles got %0d exp %0d", n, TMO + 1); end
        vecs++; if (inst !== NOP || inst_pc !== 32'h80000010 || inst_err !== 2'b11)
            begin miss++; $display("FAIL tmo_buf got %h/%h/%b exp %h/80000010/11", inst, inst_pc, inst_err, NOP); end
        inst_ready = 1'b1; #1;
        vecs++; if (pc_wen !== 1'b1) begin miss++; $display("FAIL tmo_wen got %b exp 1", pc_wen); end
        tick();
        inst_ready = 1'b0; pc = 32'h80000014; #1;
        for (int i = 0; i < 2; i++) begin
            vecs++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin miss++; $display("FAIL tmo_drop_%0d got %b/%b exp 0/0", i, req_valid, inst_valid); end
            tick(); #1;
        end
        rsp_valid = 1'b1; rsp_data = 32'hbad0bad0;
        tick();
        rsp_valid = 1'b0; #1;
        vecs++; if (req_valid !== 1'b1 || req_addr !== 32'h80000014 || inst_valid !== 1'b0)
            begin miss++; $display("FAIL tmo_rereq got %b/%h/%b exp 1/80000014/0", req_valid, req_addr, inst_valid); end
    endtask

    task automatic test_flush();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0; flush = 1'b1; pc = 32'h80000100; #1;
        vecs++; if (inst_valid !== 1'b0 || req_valid !== 1'b0) begin miss++; $display("FAIL fl_wait got %b/%b exp 0/0", inst_valid, req_valid); end
        tick();
        flush = 1'b0; #1;
        vecs++; if (req_valid !== 1'b0) begin miss++; $display("FAIL fl_drop got %b exp 0", req_valid); end
        rsp_valid = 1'b1; rsp_data = 32'h12345678;
        tick();
        rsp_valid = 1'b0; #1;
        vecs++; if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h80000100)
            begin miss++; $display("FAIL fl_rereq got %b/%b/%h exp 0/1/80000100", inst_valid, req_valid, req_addr); end
        // flush together with the response in WAIT
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0; flush = 1'b1; rsp_valid = 1'b1; pc = 32'h80000200;
        tick();
        flush = 1'b0; rsp_valid = 1'b0; #1;
        vecs++; if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h80000200)
            begin miss++; $display("FAIL fl_rsp got %b/%b/%h exp 0/1/80000200", inst_valid, req_valid, req_addr); end
        // flush beats inst_ready in HOLD
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h00000011;
        tick();
        rsp_valid = 1'b0; flush = 1'b1; inst_ready = 1'b1; pc = 32'h80000300; #1;
        vecs++; if (pc_wen !== 1'b0 || inst_valid !== 1'b0) begin miss++; $display("FAIL fl_hold got %b/%b exp 0/0", pc_wen, inst_valid); end
        tick();
        flush = 1'b0; inst_ready = 1'b0; #1;
        vecs++; if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h80000300)
            begin miss++; $display("FAIL fl_hold_next got %b/%b/%h exp 0/1/80000300", inst_valid, req_valid, req_addr); end
        // reset in WAIT
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0; rstn = 1'b0; rsp_valid = 1'b1;
        tick();
        vecs++; if ({req_valid, pc_wen, inst_valid} !== 3'b000 || inst !== NOP || inst_pc !== 32'h0 || inst_err !== 2'b00 || req_addr !== 32'h0)
            begin miss++; $display("FAIL rst_wait got %b/%h/%h/%b/%h exp 000/%h/0/00/0", {req_valid, pc_wen, inst_valid}, inst, inst_pc, inst_err, req_addr, NOP); end
        rstn = 1'b1; rsp_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] r_data, e_inst;
        logic [1:0]  e_err;
        logic        r_err;
        bit          outst, p_wen, p_hs;
        int          wcnt, idle, fetches;
        do_reset();
        pc = 32'h80001000; outst = 0; p_wen = 0; p_hs = 0; wcnt = 0;
        idle = 0; fetches = 0; r_err = 1'b0; r_data = '0;
        for (int c = 0; c < 3000; c++) begin
            if (p_wen) pc = {pc[31:2], 2'b00} + (($urandom_range(0, 7) == 0) ? 32'd6 : 32'd4);
            if (p_hs) begin
                outst = 1; wcnt = $urandom_range(0, 5);
                r_data = memw(pc); r_err = ($urandom_range(0, 7) == 0);
            end
            rsp_valid = 1'b0;
            if (outst) begin
                if (wcnt == 0) begin
                    rsp_valid = 1'b1; rsp_err = r_err;
                    rsp_data = r_err ? $urandom : r_data;
                    outst = 0;
                end else wcnt--;
            end
            req_ready  = ($urandom_range(0, 2) != 0);
            inst_ready = ($urandom_range(0, 2) == 0);
            #1;
            if (req_valid === 1'b1) begin
                vecs++; if (req_addr !== pc || pc[1:0] != 2'b00) begin miss++; $display("FAIL rnd_req c=%0d got %h exp %h", c, req_addr, pc); end
            end
            vecs++; if (pc_wen !== (inst_valid & inst_ready)) begin miss++; $display("FAIL rnd_wen c=%0d got %b exp %b", c, pc_wen, inst_valid & inst_ready); end
            if (inst_valid === 1'b1) begin
                if (pc[1:0] != 2'b00) begin e_inst = NOP; e_err = 2'b01; end
                else if (r_err)       begin e_inst = NOP; e_err = 2'b10; end
                else                  begin e_inst = memw(pc); e_err = 2'b00; end
                vecs++; if (inst !== e_inst || inst_pc !== pc || inst_err !== e_err || outst || rsp_valid)
                    begin miss++; $display("FAIL rnd_inst c=%0d got %h/%h/%b exp %h/%h/%b", c, inst, inst_pc, inst_err, e_inst, pc, e_err); end
            end
            if (pc_wen === 1'b1) begin fetches++; idle = 0; end else idle++;
            if (idle > 60) begin
                miss++; $display("FAIL rnd_stall c=%0d got no pc_wen for %0d cycles exp <=60", c, idle);
                break;
            end
            p_wen = (pc_wen === 1'b1);
            p_hs  = (req_valid === 1'b1) && req_ready;
            tick();
        end
        vecs++; if (fetches < 100) begin miss++; $display("FAIL rnd_progress got %0d fetches exp >=100", fetches); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_req_stall();
        test_hold_stall();
        test_misaligned();
        test_timeout();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish exp finish before 1000000");
        $fatal(1, "watchdog expired");
    end

endmodule
